pwm_duty_selector: RTL and testbench

Upstream control stage for the PWM generator: turns two raw pushbuttons and an auto-mode switch into the 2-bit `duty_cycle` code the generator consumes. Each button goes through synchronisation, debouncing and edge detection before the code is stepped up or down. An auto mode sweeps the code as a triangle ramp for demo and bring-up. `duty_cycle` connects straight to the generator's `duty_cycle` input on the same clock.

---
 rtl/pwm_duty_selector.sv | 147 ++++++++++++++
 tb/tb_pwm_duty_selector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_selector.sv
// rtl/pwm_duty_selector.sv - button/auto-ramp front end producing the 2-bit PWM duty code
module pwm_duty_selector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RAMP_PERIOD     = 16,
  parameter int WRAP            = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  output logic [1:0] duty_cycle,
  output logic       duty_change,
  output logic       auto_active
);

  // Debounce counter must hold DEBOUNCE_CYCLES-1; +1 keeps the width non-zero when D = 1.
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = $clog2(RAMP_PERIOD);

  typedef enum logic [1:0] {MANUAL, RAMP_UP, RAMP_DOWN} state_t;

  // Bit 0 = up button, bit 1 = down button, bit 2 = auto switch (synchroniser only).
  logic [2:0]          meta_q, meta_d;
  logic [2:0]          sync_q, sync_d;
  logic [1:0][DCW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          stable_prev_q, stable_prev_d;
  logic [1:0]          press;

  state_t              state_q, state_d;
  logic [RCW-1:0]      ramp_cnt_q, ramp_cnt_d;
  logic [1:0]          duty_q, duty_d;
  logic                duty_change_q, duty_change_d;
  logic                auto_active_q, auto_active_d;

  logic                up_evt, dn_evt, auto_s, ramp_wrap;

  // Synchronise the raw inputs and debounce both buttons into stable levels.
  always_comb begin
    meta_d        = {auto_en, btn_down, btn_up};
    sync_d        = meta_q;
    stable_d      = stable_q;
    db_cnt_d      = db_cnt_q;
    stable_prev_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = ~stable_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Only rising edges of the debounced level count as presses; releases are silent.
  assign press  = stable_q & ~stable_prev_q;
  assign up_evt = press[0] & ~press[1];
  assign dn_evt = press[1] & ~press[0];
  assign auto_s = sync_q[2];
  assign ramp_wrap = (ramp_cnt_q == RCW'(RAMP_PERIOD - 1));

  // Next state, ramp timer and duty code; auto mode takes priority over buttons.
  always_comb begin
    state_d    = state_q;
    ramp_cnt_d = ramp_cnt_q;
    duty_d     = duty_q;
    case (state_q)
      MANUAL: begin
        if (auto_s) begin
          state_d    = (duty_q == 2'd3) ? RAMP_DOWN : RAMP_UP;
          ramp_cnt_d = '0;
        end else if (up_evt) begin
          if (duty_q != 2'd3)  duty_d = duty_q + 2'd1;
          else if (WRAP != 0)  duty_d = 2'd0;
        end else if (dn_evt) begin
          if (duty_q != 2'd0)  duty_d = duty_q - 2'd1;
          else if (WRAP != 0)  duty_d = 2'd3;
        end
      end
      RAMP_UP: begin
        if (!auto_s) begin
          state_d    = MANUAL;
          ramp_cnt_d = '0;
        end else if (ramp_wrap) begin
          ramp_cnt_d = '0;
          duty_d     = duty_q + 2'd1;
          if (duty_q == 2'd2) state_d = RAMP_DOWN;
        end else begin
          ramp_cnt_d = ramp_cnt_q + 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (!auto_s) begin
          state_d    = MANUAL;
          ramp_cnt_d = '0;
        end else if (ramp_wrap) begin
          ramp_cnt_d = '0;
          duty_d     = duty_q - 2'd1;
          if (duty_q == 2'd1) state_d = RAMP_UP;
        end else begin
          ramp_cnt_d = ramp_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = MANUAL;
        ramp_cnt_d = '0;
      end
    endcase
    duty_change_d = (duty_d != duty_q);
    auto_active_d = (state_d != MANUAL);
  end

  // All state registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q        <= '0;
      sync_q        <= '0;
      db_cnt_q      <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      state_q       <= MANUAL;
      ramp_cnt_q    <= '0;
      duty_q        <= 2'd0;
      duty_change_q <= 1'b0;
      auto_active_q <= 1'b0;
    end else begin
      meta_q        <= meta_d;
      sync_q        <= sync_d;
      db_cnt_q      <= db_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      state_q       <= state_d;
      ramp_cnt_q    <= ramp_cnt_d;
      duty_q        <= duty_d;
      duty_change_q <= duty_change_d;
      auto_active_q <= auto_active_d;
    end
  end

  assign duty_cycle  = duty_q;
  assign duty_change = duty_change_q;
  assign auto_active = auto_active_q;

endmodule

// File: tb/tb_pwm_duty_selector.sv
// tb/tb_pwm_duty_selector.sv - directed self-checking bench for pwm_duty_selector
module tb_pwm_duty_selector;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, auto_en;
  logic       btn_up_w, btn_down_w, auto_w;
  logic [1:0] duty, duty_w;
  logic       chg, chg_w, act, act_w;
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  int         pulses_w = 0;

  always #5 clk = ~clk;

  pwm_duty_selector #(.DEBOUNCE_CYCLES(4), .RAMP_PERIOD(8), .WRAP(0)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .auto_en(auto_en),
    .duty_cycle(duty), .duty_change(chg), .auto_active(act)
  );

  pwm_duty_selector #(.DEBOUNCE_CYCLES(4), .RAMP_PERIOD(8), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .btn_up(btn_up_w), .btn_down(btn_down_w), .auto_en(auto_w),
    .duty_cycle(duty_w), .duty_change(chg_w), .auto_active(act_w)
  );

  // duty_change pulse tally, sampled 1 ns after each rising edge
  always @(posedge clk) begin
    #1;
    if (chg === 1'b1)   pulses++;
    if (chg_w === 1'b1) pulses_w++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] t2_exp [4];
    logic [1:0] t2_prev;
    logic [1:0] t5_exp [7];
    int         base;
    t2_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
    t5_exp = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};

    // 1: reset with btn_up held, one increment at edge 6 after release
    reset = 1'b1; btn_up = 1'b1; btn_down = 1'b0; auto_en = 1'b0;
    btn_up_w = 1'b0; btn_down_w = 1'b0; auto_w = 1'b0;
    #12;
    check("rst_duty", 32'(duty), 0);
    check("rst_change", 32'(chg), 0);
    check("rst_auto_active", 32'(act), 0);
    @(negedge clk);
    reset = 1'b0;
    step(6);
    check("t1_before_edge6", 32'(duty), 0);
    step(1);
    check("t1_duty_edge6", 32'(duty), 1);
    check("t1_change_edge6", 32'(chg), 1);
    step(1);
    check("t1_change_one_cycle", 32'(chg), 0);
    check("t1_pulse_count", 32'(pulses), 1);

    // 2: four up presses from 0 -> 1,2,3,3 (saturates)
    btn_up = 1'b0;
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t2_start", 32'(duty), 0);
    base = pulses;
    t2_prev = 2'd0;
    for (int k = 0; k < 4; k++) begin
      btn_up = 1'b1;
      step(6);
      check("t2_hold_before", 32'(duty), 32'(t2_prev));
      step(1);
      check("t2_duty", 32'(duty), 32'(t2_exp[k]));
      check("t2_change", 32'(chg), (t2_exp[k] != t2_prev) ? 1 : 0);
      t2_prev = t2_exp[k];
      step(3);
      btn_up = 1'b0;
      step(10);
    end
    check("t2_pulse_count", 32'(pulses - base), 3);

    // 3: down to 2, then glitchy btn_down must be rejected
    btn_down = 1'b1;
    step(10);
    btn_down = 1'b0;
    step(10);
    check("t3_start", 32'(duty), 2);
    base = pulses;
    btn_down = 1'b1;
    step(3);
    for (int i = 0; i < 20; i++) begin
      btn_down = i[0];
      step(1);
    end
    btn_down = 1'b0;
    step(10);
    check("t3_duty_held", 32'(duty), 2);
    check("t3_no_pulses", 32'(pulses - base), 0);

    // 4: WRAP=1 instance, 0 -down-> 3 -up-> 0
    base = pulses_w;
    btn_down_w = 1'b1;
    step(6);
    check("t4_before", 32'(duty_w), 0);
    step(1);
    check("t4_wrap_down", 32'(duty_w), 3);
    check("t4_wrap_down_change", 32'(chg_w), 1);
    step(3);
    btn_down_w = 1'b0;
    step(10);
    btn_up_w = 1'b1;
    step(7);
    check("t4_wrap_up", 32'(duty_w), 0);
    check("t4_wrap_up_change", 32'(chg_w), 1);
    step(3);
    btn_up_w = 1'b0;
    step(10);
    check("t4_pulse_count", 32'(pulses_w - base), 2);
    check("t4_main_untouched", 32'(duty), 2);

    // 5: auto ramp from 0, button ignored, exit at 2
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t5_start", 32'(duty), 0);
    base = pulses;
    auto_en = 1'b1;
    step(2);
    check("t5_active_not_yet", 32'(act), 0);
    step(1);
    check("t5_active", 32'(act), 1);
    step(7);
    check("t5_before_first_step", 32'(duty), 0);
    step(1);
    check("t5_first_step", 32'(duty), 1);
    check("t5_first_change", 32'(chg), 1);
    btn_up = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(8);
      if (k == 0) btn_up = 1'b0;
      check("t5_ramp_duty", 32'(duty), 32'(t5_exp[k]));
      check("t5_ramp_change", 32'(chg), 1);
    end
    auto_en = 1'b0;
    step(2);
    check("t5_active_still", 32'(act), 1);
    step(1);
    check("t5_exit_active", 32'(act), 0);
    check("t5_exit_duty", 32'(duty), 2);
    step(20);
    check("t5_hold_duty", 32'(duty), 2);
    check("t5_pulse_count", 32'(pulses - base), 8);

    // 6: simultaneous up/down does nothing; async reset mid-ramp
    base = pulses;
    btn_up = 1'b1; btn_down = 1'b1;
    step(10);
    btn_up = 1'b0; btn_down = 1'b0;
    step(10);
    check("t6_both_duty", 32'(duty), 2);
    check("t6_both_no_pulse", 32'(pulses - base), 0);
    auto_en = 1'b1;
    step(11);
    check("t6_ramp_at3", 32'(duty), 3);
    check("t6_ramp_active", 32'(act), 1);
    step(3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_duty", 32'(duty), 0);
    check("t6_async_active", 32'(act), 0);
    check("t6_async_change", 32'(chg), 0);
    @(negedge clk);
    reset = 1'b0;
    auto_en = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
